// File: rtl/sm_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sm_uart_tx_pkg
// Description : Shared definitions for the sm_uart_tx peripheral: register
//               offsets, STATUS bit positions and the transmitter FSM states.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sm_uart_tx_pkg;

   // Register byte offsets relative to BASE_ADDR
   localparam logic [31:0] TXDATA_OFS = 32'd0;
   localparam logic [31:0] STATUS_OFS = 32'd4;

   // STATUS word bit positions
   localparam int ST_FULL_BIT  = 0;
   localparam int ST_EMPTY_BIT = 1;
   localparam int ST_BUSY_BIT  = 2;
   localparam int ST_OVF_BIT   = 3;
   localparam int ST_CNT_LSB   = 4;
   localparam int ST_CNT_W     = 4;

   // Transmitter FSM encoding
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage : sm_uart_tx_pkg
`default_nettype wire

// File: rtl/sm_fifo_sync.sv
`default_nettype none
// ============================================================================
// Module      : sm_fifo_sync
// Description : Parameterised synchronous first-word-fall-through FIFO.
//               A push while full is accepted when a pop happens on the
//               same edge.
// Ports       : clk, rst    - clock, synchronous active-high reset
//               push, din   - write request and data
//               pop, dout   - read request and head-of-queue data
//               full, empty - occupancy flags
//               count       - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module sm_fifo_sync #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] C_FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   logic w_do_pop;
   logic w_do_push;

   // A pop frees a slot on the same edge, so a push into a full FIFO is
   // still accepted when it coincides with a pop.
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end

   assign dout  = r_mem[r_rd_ptr];
   assign full  = (r_count == C_FULL_COUNT);
   assign empty = (r_count == '0);
   assign count = r_count;

endmodule : sm_fifo_sync
`default_nettype wire

// File: rtl/sm_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : sm_uart_tx
// Description : Memory-mapped 8N1 UART transmitter. Bytes written to TXDATA
//               are queued in a FIFO and shifted out LSB first on txd.
//               STATUS reports full/empty/busy/overflow/count.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               busAddr        - CPU byte address
//               ioWriteEnable  - I/O write strobe
//               ioData         - write data
//               readData       - STATUS word when addressed, else 0
//               txd            - serial output, idle high
//               irqEmpty       - FIFO empty and transmitter idle
// Revision    : 1.0 - initial release
// ============================================================================
module sm_uart_tx
   import sm_uart_tx_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
   parameter int          CLK_DIV    = 16,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] busAddr,
   input  logic        ioWriteEnable,
   input  logic [31:0] ioData,
   output logic [31:0] readData,
   output logic        txd,
   output logic        irqEmpty
);

   localparam int          CW             = $clog2(FIFO_DEPTH) + 1;
   localparam logic [31:0] C_TXDATA_ADDR  = BASE_ADDR + TXDATA_OFS;
   localparam logic [31:0] C_STATUS_ADDR  = BASE_ADDR + STATUS_OFS;
   localparam logic [15:0] C_BAUD_RELOAD  = 16'(CLK_DIV - 1);

   tx_state_t    r_state;
   logic         r_txd;
   logic [15:0]  r_baud;
   logic [2:0]   r_bit_idx;
   logic [7:0]   r_shift;
   logic         r_ovf;

   logic         w_txdata_wr;
   logic         w_status_wr;
   logic         w_pop;
   logic         w_full;
   logic         w_empty;
   logic [7:0]   w_fifo_dout;
   logic [CW-1:0] w_count;
   logic [4:0]   w_count_ext;
   logic         w_busy;
   logic [31:0]  w_status;
   logic         w_unused_data;

   assign w_unused_data = ^ioData[31:8];

   assign w_txdata_wr = ioWriteEnable && (busAddr == C_TXDATA_ADDR);
   assign w_status_wr = ioWriteEnable && (busAddr == C_STATUS_ADDR);

   // The transmitter fetches the next byte only from IDLE; that edge is
   // also the one that frees a FIFO slot for a same-edge push.
   assign w_pop = (r_state == IDLE) && !w_empty;

   sm_fifo_sync #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_txdata_wr),
      .din   (ioData[7:0]),
      .pop   (w_pop),
      .dout  (w_fifo_dout),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   // Transmitter FSM. txd is registered and updated on the same edge as
   // the state change, so the line level always matches the current state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_txd     <= 1'b1;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_txd <= 1'b1;
               if (!w_empty) begin
                  r_shift <= w_fifo_dout;
                  r_baud  <= C_BAUD_RELOAD;
                  r_txd   <= 1'b0;
                  r_state <= START;
               end
            end
            START: begin
               if (r_baud == '0) begin
                  r_baud    <= C_BAUD_RELOAD;
                  r_bit_idx <= '0;
                  r_txd     <= r_shift[0];
                  r_state   <= DATA;
               end else begin
                  r_baud <= r_baud - 1'b1;
               end
            end
            DATA: begin
               if (r_baud == '0) begin
                  r_baud <= C_BAUD_RELOAD;
                  if (r_bit_idx == 3'd7) begin
                     r_txd   <= 1'b1;
                     r_state <= STOP;
                  end else begin
                     // Next bit is shift[1] before the shift takes effect
                     r_shift   <= {1'b0, r_shift[7:1]};
                     r_bit_idx <= r_bit_idx + 1'b1;
                     r_txd     <= r_shift[1];
                  end
               end else begin
                  r_baud <= r_baud - 1'b1;
               end
            end
            STOP: begin
               r_txd <= 1'b1;
               if (r_baud == '0) begin
                  r_state <= IDLE;
               end else begin
                  r_baud <= r_baud - 1'b1;
               end
            end
            default: begin
               r_txd   <= 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Sticky overflow: a dropped byte wins over a clear on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_txdata_wr && w_full && !w_pop) begin
         r_ovf <= 1'b1;
      end else if (w_status_wr && ioData[ST_OVF_BIT]) begin
         r_ovf <= 1'b0;
      end
   end

   assign w_busy      = (r_state != IDLE);
   assign w_count_ext = 5'(w_count);

   always_comb begin
      w_status                          = '0;
      w_status[ST_FULL_BIT]             = w_full;
      w_status[ST_EMPTY_BIT]            = w_empty;
      w_status[ST_BUSY_BIT]             = w_busy;
      w_status[ST_OVF_BIT]              = r_ovf;
      w_status[ST_CNT_LSB +: ST_CNT_W]  = w_count_ext[3:0];
   end

   assign readData = (busAddr == C_STATUS_ADDR) ? w_status : 32'd0;
   assign txd      = r_txd;
   assign irqEmpty = w_empty && !w_busy;

endmodule : sm_uart_tx
`default_nettype wire
